mult_div_seq: RTL and testbench
===============================

Name: mult_div_seq

Overview:
- Multicycle signed multiply/divide responder for the CPU control unit.
- The control unit is the initiator: it pulses a start with an opcode. This block iterates, then returns HI/LO results plus a divide-by-zero flag.
- Sits beside the register bank. Operands come from the A/B register outputs; results feed the HI/LO registers and the exception path.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request strobe from control unit
- op  input  2  01 = signed multiply, 10 = signed divide, 00/11 = no-op
- a_in  input  WIDTH  multiplicand / dividend
- b_in  input  WIDTH  multiplier / divisor
- busy  output  1  high while iterating (MULT or DIV state)
- done  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle pulse, coincident with done, on divide by zero
- hi_out  output  WIDTH  multiply: product[63:32]; divide: remainder
- lo_out  output  WIDTH  multiply: product[31:0]; divide: quotient

Behaviour:
- Reset (reset=0, async): state=IDLE; counter=0; busy=0, done=0, div_zero=0; hi_out=0, lo_out=0; all working registers cleared. Reset during MULT/DIV aborts the operation, and no done is produced.
- States: IDLE, MULT, DIV, DONE.
- Start acceptance:
  - start is sampled only in IDLE or DONE; start in MULT/DIV is ignored, with no effect on state or operands.
  - a_in/b_in are latched at the accepting edge (E0); later operand changes have no effect.
- Transitions at E0:
  - op=01 -> MULT, counter=0.
  - op=10 and b_in!=0 -> DIV, counter=0.
  - op=10 and b_in==0 -> DONE directly: done=1 and div_zero=1 for exactly the cycle E0..E1; hi_out/lo_out unchanged.
  - op=00/11 -> no state change; done is not asserted.
- MULT:
  - Radix-2 Booth over a 2*WIDTH+1 accumulator {A, Q, q-1}: one add/subtract plus arithmetic right shift per edge.
  - WIDTH iterations at edges E1..E32.
  - At E32: hi_out/lo_out load the signed 64-bit product; state -> DONE.
- DIV:
  - Restoring division on magnitudes |a|, |b|, one quotient bit per edge, edges E1..E32.
  - At E32, sign correction applied on the load:
    - quotient negated if sign(a) XOR sign(b);
    - remainder takes the sign of a (truncation toward zero, MIPS semantics).
  - lo_out = quotient, hi_out = remainder; state -> DONE.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0 (natural two's-complement wrap); div_zero=0.
- DONE:
  - done=1 for one cycle, then IDLE unless a new start is accepted.
  - div_zero=1 only when entered via the zero-divisor path.
- busy: 1 exactly in MULT/DIV, i.e. from E0 through E32 (32 cycles); 0 in IDLE/DONE.
- Latency, nonzero operation: done visible in the cycle after E32 (33 edges after the start edge counting E0).
- hi_out/lo_out hold their value until the next successful completion; they are never written mid-iteration.
- Counter is 6 bits; it wraps to 0 on exit from MULT/DIV. No state persists across operations beyond hi_out/lo_out.

Test Plan:
- Multiply 7 * -3: a_in=0x00000007, b_in=0xFFFFFFFD, op=01 -> busy for 32 cycles; done pulse 1 cycle; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; div_zero=0.
- Divide 100 / 7, then -7 / 2:
  - 100 / 7 -> lo_out=0x0000000E, hi_out=0x00000002.
  - 0xFFFFFFF9 / 0x00000002 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- Divide by zero: preload hi/lo with 0x12345678/0x9ABCDEF0, then op=10, b_in=0 -> done and div_zero high in the cycle right after the start edge; busy never high; hi/lo unchanged.
- Overflow divide 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0x00000000, div_zero=0. Multiply 0x80000000 * 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- start pulsed with different op/operands at cycle 10 of a running multiply -> ignored; original product delivered at the original done cycle. A back-to-back start during DONE is accepted, and its busy rises at the next cycle.
- Assert reset low mid-divide (cycle 15) -> all outputs 0 immediately (asynchronous); after release the block is IDLE, with no done pulse; a fresh multiply 3 * 5 gives lo_out=0x0000000F, hi_out=0.

Source files
------------

// File: rtl/mult_div_seq.sv
// ---------------------------------------------------------------------------
// mult_div_seq
//
// Multicycle signed multiply / divide unit that sits beside the register bank.
// The control unit pulses start with an opcode; the block iterates one step
// per clock (radix-2 Booth for multiply, restoring division for divide) and
// then presents HI/LO results together with a one-cycle done pulse.
//
// Ports:
//   clk       system clock, rising edge active
//   reset     asynchronous, active-low reset
//   start     single-cycle request strobe, sampled only in IDLE or DONE
//   op        01 = signed multiply, 10 = signed divide, 00/11 = no-op
//   a_in      multiplicand / dividend, captured on the accepting edge
//   b_in      multiplier / divisor, captured on the accepting edge
//   busy      high while iterating (MULT or DIV)
//   done      one-cycle completion pulse (DONE state)
//   div_zero  one-cycle pulse coincident with done on a zero divisor
//   hi_out    multiply: product upper half; divide: remainder
//   lo_out    multiply: product lower half; divide: quotient
// ---------------------------------------------------------------------------
module mult_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int               CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
   localparam logic [1:0]       OP_MUL    = 2'b01;
   localparam logic [1:0]       OP_DIV    = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MULT = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] count_q,   count_d;
   // acc_a holds the Booth upper accumulator or the division partial
   // remainder; acc_q holds the multiplier / dividend that shifts out as the
   // product low half / quotient accumulates.
   logic [WIDTH:0]   acc_a_q,   acc_a_d;
   logic [WIDTH-1:0] acc_q_q,   acc_q_d;
   logic             q_m1_q,    q_m1_d;
   logic [WIDTH-1:0] opnd_m_q,  opnd_m_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q,      dz_d;
   logic [WIDTH-1:0] hi_q,      hi_d;
   logic [WIDTH-1:0] lo_q,      lo_d;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   booth_a_next;
   logic [WIDTH-1:0] booth_q_next;
   logic             booth_qm1_next;

   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH:0]   div_rem_next;
   logic             div_fits;
   logic [WIDTH-1:0] div_quo_next;
   logic [WIDTH-1:0] quo_signed;
   logic [WIDTH-1:0] rem_signed;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // One Booth step. The upper accumulator carries one guard bit beyond the
   // operand width so that adding or subtracting the most negative
   // multiplicand cannot overflow; the low 2*WIDTH bits of {acc_a, acc_q}
   // are the product once all steps are done.
   always_comb begin
      m_ext     = {opnd_m_q[WIDTH-1], opnd_m_q};
      booth_sum = acc_a_q;
      case ({acc_q_q[0], q_m1_q})
         2'b01:   booth_sum = acc_a_q + m_ext;
         2'b10:   booth_sum = acc_a_q - m_ext;
         default: booth_sum = acc_a_q;
      endcase
      booth_a_next   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      booth_q_next   = {booth_sum[0], acc_q_q[WIDTH-1:1]};
      booth_qm1_next = acc_q_q[0];
   end

   // One restoring-division step on magnitudes. The partial remainder always
   // stays below the divisor (at most 2^(WIDTH-1)), so the shifted value fits
   // in WIDTH bits and the top bit of the difference is a clean borrow flag.
   always_comb begin
      div_shift    = {acc_a_q[WIDTH-1:0], acc_q_q[WIDTH-1]};
      div_diff     = div_shift - {1'b0, opnd_m_q};
      div_fits     = ~div_diff[WIDTH];
      div_rem_next = div_fits ? div_diff : div_shift;
      div_quo_next = {acc_q_q[WIDTH-2:0], div_fits};
      quo_signed   = neg_quo_q ? -div_quo_next : div_quo_next;
      rem_signed   = neg_rem_q ? -div_rem_next[WIDTH-1:0] : div_rem_next[WIDTH-1:0];
   end

   // Operand magnitudes for division. The most negative value maps onto
   // itself, which read as unsigned is exactly its magnitude.
   always_comb begin
      a_mag = a_in[WIDTH-1] ? -a_in : a_in;
      b_mag = b_in[WIDTH-1] ? -b_in : b_in;
   end

   // Next-state and datapath control. HI/LO are only written on the final
   // iteration step, so they keep the previous result for the whole run.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_a_d   = acc_a_q;
      acc_q_d   = acc_q_q;
      q_m1_d    = q_m1_q;
      opnd_m_d  = opnd_m_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE lasts a single cycle unless a new request lands on it.
            if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
            dz_d = 1'b0;
            if (start) begin
               if (op == OP_MUL) begin
                  state_d   = ST_MULT;
                  count_d   = '0;
                  acc_a_d   = '0;
                  acc_q_d   = b_in;
                  q_m1_d    = 1'b0;
                  opnd_m_d  = a_in;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
               end else if (op == OP_DIV) begin
                  if (b_in == '0) begin
                     // Zero divisor: report immediately, leave HI/LO alone.
                     state_d = ST_DONE;
                     dz_d    = 1'b1;
                  end else begin
                     state_d   = ST_DIV;
                     count_d   = '0;
                     acc_a_d   = '0;
                     acc_q_d   = a_mag;
                     q_m1_d    = 1'b0;
                     opnd_m_d  = b_mag;
                     neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                     neg_rem_d = a_in[WIDTH-1];
                  end
               end
            end
         end

         ST_MULT: begin
            acc_a_d = booth_a_next;
            acc_q_d = booth_q_next;
            q_m1_d  = booth_qm1_next;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
               hi_d     = booth_a_next[WIDTH-1:0];
               lo_d     = booth_q_next;
               state_d  = ST_DONE;
               count_d  = '0;
               acc_a_d  = '0;
               acc_q_d  = '0;
               q_m1_d   = 1'b0;
               opnd_m_d = '0;
            end
         end

         ST_DIV: begin
            acc_a_d = div_rem_next;
            acc_q_d = div_quo_next;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
               // Truncating division: quotient sign is the XOR of the
               // operand signs, remainder follows the dividend.
               hi_d      = rem_signed;
               lo_d      = quo_signed;
               state_d   = ST_DONE;
               count_d   = '0;
               acc_a_d   = '0;
               acc_q_d   = '0;
               opnd_m_d  = '0;
               neg_quo_d = 1'b0;
               neg_rem_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         acc_a_q   <= '0;
         acc_q_q   <= '0;
         q_m1_q    <= 1'b0;
         opnd_m_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_a_q   <= acc_a_d;
         acc_q_q   <= acc_q_d;
         q_m1_q    <= q_m1_d;
         opnd_m_q  <= opnd_m_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
   assign done     = (state_q == ST_DONE);
   assign div_zero = (state_q == ST_DONE) && dz_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_div_seq
//
// Self-checking bench for mult_div_seq. Expected results come from plain
// 64-bit signed arithmetic on the operands; inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_hi      = '0;
   logic [31:0] exp_lo      = '0;

   always #5 clk = ~clk;

   mult_div_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   // Reference: signed product / truncating quotient and remainder. A zero
   // divisor finishes one cycle after the start edge and keeps HI/LO.
   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat);
      longint sa, sb, p, q, r;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      hi  = exp_hi;
      lo  = exp_lo;
      dz  = 1'b0;
      lat = 33;
      if (o == 2'b01) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dz  = 1'b1;
         lat = 1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   // Pulse start for one edge, then scramble operands to prove they were
   // latched. Returns on the falling edge right after the accepting edge.
   task automatic issue_op(input bit now, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b);
      if (!now) @(negedge clk);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      a_in  = $urandom;
      b_in  = $urandom;
   endtask

   // Wait (bounded) for done. lat counts falling edges since the start edge;
   // inject_at pulses a bogus divide request at that count.
   task automatic wait_done(input int inject_at, output int lat, output int busy_cycles,
                            output bit dz_seen, output bit timed_out);
      lat         = 1;
      busy_cycles = 0;
      dz_seen     = 1'b0;
      timed_out   = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (done) begin
            dz_seen   = div_zero;
            timed_out = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         if (lat == inject_at) begin
            start = 1'b1;
            op    = 2'b10;
            a_in  = $urandom;
            b_in  = $urandom | 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a_in  = '0;
      b_in  = '0;
      #12;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
      vectors++; if (hi_out !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 00000000", hi_out); end
      vectors++; if (lo_out !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 00000000", lo_out); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   task automatic test_multiply();
      logic [31:0] ta[4] = '{32'h00000007, 32'h80000000, 32'h00000003, 32'hFFFFFFFF};
      logic [31:0] tb[4] = '{32'hFFFFFFFD, 32'h80000000, 32'h00000005, 32'h7FFFFFFF};
      logic [31:0] th[4] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000000, 32'hFFFFFFFF};
      logic [31:0] tl[4] = '{32'hFFFFFFEB, 32'h00000000, 32'h0000000F, 32'h80000001};
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to;
      for (int i = 0; i < 12; i++) begin
         if (i < 4) begin
            a = ta[i]; b = tb[i]; ehi = th[i]; elo = tl[i]; edz = 1'b0; elat = 33;
         end else begin
            a = $urandom; b = $urandom;
            model(2'b01, a, b, ehi, elo, edz, elat);
         end
         issue_op(1'b0, 2'b01, a, b);
         wait_done(-1, lat, bc, dz, to);
         vectors++; if (lat !== elat) begin miscompares++; $display("FAIL mul_latency[%0d]: got %0d expected %0d (timeout=%b)", i, lat, elat, to); end
         vectors++; if (bc !== 32) begin miscompares++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected 32", i, bc); end
         vectors++; if (dz !== edz) begin miscompares++; $display("FAIL mul_div_zero[%0d]: got %b expected %b", i, dz, edz); end
         vectors++; if (hi_out !== ehi) begin miscompares++; $display("FAIL mul_hi[%0d] %h*%h: got %h expected %h", i, a, b, hi_out, ehi); end
         vectors++; if (lo_out !== elo) begin miscompares++; $display("FAIL mul_lo[%0d] %h*%h: got %h expected %h", i, a, b, lo_out, elo); end
         exp_hi = ehi;
         exp_lo = elo;
         @(negedge clk);
         vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mul_done_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy); end
      end
   endtask

   task automatic test_divide();
      logic [31:0] ta[4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h00000007};
      logic [31:0] tb[4] = '{32'd7,   32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      logic [31:0] th[4] = '{32'h2,   32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      logic [31:0] tl[4] = '{32'hE,   32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD};
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to;
      for (int i = 0; i < 14; i++) begin
         if (i < 4) begin
            a = ta[i]; b = tb[i]; ehi = th[i]; elo = tl[i]; edz = 1'b0; elat = 33;
         end else begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 30);
            if (b == 32'd0) b = 32'd9;
            if (i == 13) a = 32'h80000000;
            model(2'b10, a, b, ehi, elo, edz, elat);
         end
         issue_op(1'b0, 2'b10, a, b);
         wait_done(-1, lat, bc, dz, to);
         vectors++; if (lat !== elat) begin miscompares++; $display("FAIL div_latency[%0d]: got %0d expected %0d (timeout=%b)", i, lat, elat, to); end
         vectors++; if (bc !== 32) begin miscompares++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 32", i, bc); end
         vectors++; if (dz !== edz) begin miscompares++; $display("FAIL div_div_zero[%0d]: got %b expected %b", i, dz, edz); end
         vectors++; if (hi_out !== ehi) begin miscompares++; $display("FAIL div_rem[%0d] %h/%h: got %h expected %h", i, a, b, hi_out, ehi); end
         vectors++; if (lo_out !== elo) begin miscompares++; $display("FAIL div_quo[%0d] %h/%h: got %h expected %h", i, a, b, lo_out, elo); end
         exp_hi = ehi;
         exp_lo = elo;
         @(negedge clk);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to;
      // Load HI/LO with a known nonzero product first.
      a = $urandom | 32'h00010001;
      b = $urandom | 32'h00010001;
      model(2'b01, a, b, ehi, elo, edz, elat);
      issue_op(1'b0, 2'b01, a, b);
      wait_done(-1, lat, bc, dz, to);
      vectors++; if (hi_out !== ehi || lo_out !== elo) begin miscompares++; $display("FAIL dz_preload: got %h_%h expected %h_%h", hi_out, lo_out, ehi, elo); end
      exp_hi = ehi;
      exp_lo = elo;
      a = $urandom;
      model(2'b10, a, 32'd0, ehi, elo, edz, elat);
      issue_op(1'b0, 2'b10, a, 32'd0);
      wait_done(-1, lat, bc, dz, to);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL dz_latency: got %0d expected %0d", lat, elat); end
      vectors++; if (bc !== 0) begin miscompares++; $display("FAIL dz_busy_cycles: got %0d expected 0", bc); end
      vectors++; if (dz !== edz) begin miscompares++; $display("FAIL dz_flag: got %b expected %b", dz, edz); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL dz_busy_at_done: got %b expected 0", busy); end
      vectors++; if (hi_out !== ehi || lo_out !== elo) begin miscompares++; $display("FAIL dz_hilo_kept: got %h_%h expected %h_%h", hi_out, lo_out, ehi, elo); end
      @(negedge clk);
      vectors++; if (done !== 1'b0 || div_zero !== 1'b0) begin miscompares++; $display("FAIL dz_pulse_width: got done=%b div_zero=%b expected 0 0", done, div_zero); end
   endtask

   task automatic test_noop();
      logic [1:0] ops[2] = '{2'b00, 2'b11};
      bit         seen;
      for (int i = 0; i < 2; i++) begin
         issue_op(1'b0, ops[i], $urandom, $urandom);
         seen = 1'b0;
         for (int c = 0; c < 6; c++) begin
            if (done || busy || div_zero) seen = 1'b1;
            @(negedge clk);
         end
         vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL noop_activity[%0d]: got activity=%b expected 0", i, seen); end
         vectors++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin miscompares++; $display("FAIL noop_hilo[%0d]: got %h_%h expected %h_%h", i, hi_out, lo_out, exp_hi, exp_lo); end
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to;
      a = $urandom;
      b = $urandom;
      model(2'b01, a, b, ehi, elo, edz, elat);
      issue_op(1'b0, 2'b01, a, b);
      wait_done(10, lat, bc, dz, to);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL ign_latency: got %0d expected %0d", lat, elat); end
      vectors++; if (dz !== edz) begin miscompares++; $display("FAIL ign_div_zero: got %b expected %b", dz, edz); end
      vectors++; if (hi_out !== ehi || lo_out !== elo) begin miscompares++; $display("FAIL ign_product: got %h_%h expected %h_%h", hi_out, lo_out, ehi, elo); end
      exp_hi = ehi;
      exp_lo = elo;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to;
      a = $urandom;
      b = $urandom;
      model(2'b01, a, b, ehi, elo, edz, elat);
      issue_op(1'b0, 2'b01, a, b);
      wait_done(-1, lat, bc, dz, to);
      vectors++; if (hi_out !== ehi || lo_out !== elo) begin miscompares++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hi_out, lo_out, ehi, elo); end
      exp_hi = ehi;
      exp_lo = elo;
      // Still in the done cycle: the next request lands on DONE.
      a = $urandom;
      b = $urandom | 32'd1;
      model(2'b10, a, b, ehi, elo, edz, elat);
      issue_op(1'b1, 2'b10, a, b);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_rise: got %b expected 1", busy); end
      wait_done(-1, lat, bc, dz, to);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL b2b_latency: got %0d expected %0d", lat, elat); end
      vectors++; if (hi_out !== ehi || lo_out !== elo) begin miscompares++; $display("FAIL b2b_second: got %h_%h expected %h_%h", hi_out, lo_out, ehi, elo); end
      exp_hi = ehi;
      exp_lo = elo;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      logic [31:0] ehi, elo;
      logic        edz;
      int          elat, lat, bc;
      bit          dz, to, seen_done, seen_busy;
      issue_op(1'b0, 2'b10, 32'd1000000, 32'd3);
      repeat (14) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, div_zero); end
      vectors++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin miscompares++; $display("FAIL rst_mid_hilo: got %h_%h expected 00000000_00000000", hi_out, lo_out); end
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      reset     = 1'b1;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         if (busy) seen_busy = 1'b1;
      end
      vectors++; if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_done: got done=%b busy=%b expected 0 0", seen_done, seen_busy); end
      model(2'b01, 32'd3, 32'd5, ehi, elo, edz, elat);
      issue_op(1'b0, 2'b01, 32'd3, 32'd5);
      wait_done(-1, lat, bc, dz, to);
      vectors++; if (lat !== 33) begin miscompares++; $display("FAIL rst_fresh_latency: got %0d expected 33", lat); end
      vectors++; if (hi_out !== 32'h0 || lo_out !== 32'hF) begin miscompares++; $display("FAIL rst_fresh_mul: got %h_%h expected 00000000_0000000f", hi_out, lo_out); end
      exp_hi = ehi;
      exp_lo = elo;
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_div_zero();
      test_noop();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_div();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
